// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - pipelined add/subtract with carry, overflow and valid/ready backpressure
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   flush           synchronous drop of every in-flight word
//   in_valid/ready  upstream handshake for the operand set {a, b, ci, sub}
//   out_valid/ready downstream handshake for the result {sum, co, ovf}
//   occupancy       number of valid words currently in the pipeline

module adder_pipe #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf,
  output logic [4:0]       occupancy
);

  logic [LATENCY-1:0] v;
  logic [LATENCY-1:0] rdy;
  logic [WIDTH-1:0]   sum_q [LATENCY];
  logic               co_q  [LATENCY];
  logic               ovf_q [LATENCY];

  logic [WIDTH-1:0] bb;
  logic [WIDTH:0]   total;
  logic             ovf_c;
  logic             accept;

  // Subtraction is a + ~b + ci, so a plain subtract needs ci=1.
  assign bb     = sub ? ~b : b;
  assign total  = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, ci};
  assign ovf_c  = (a[WIDTH-1] == bb[WIDTH-1]) && (total[WIDTH-1] != a[WIDTH-1]);

  // Stage k can take a new word unless it and every stage after it are
  // full while the output is stalled; this is what collapses bubbles.
  for (genvar k = 0; k < LATENCY; k++) begin : g_rdy
    assign rdy[k] = out_ready || !(&v[LATENCY-1:k]);
  end

  assign in_ready = rdy[0] && !flush && !rst;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        sum_q[k] <= '0;
        co_q[k]  <= 1'b0;
        ovf_q[k] <= 1'b0;
      end
    end else if (flush) begin
      v <= '0;
    end else begin
      if (rdy[0]) begin
        v[0]     <= accept;
        sum_q[0] <= total[WIDTH-1:0];
        co_q[0]  <= total[WIDTH];
        ovf_q[0] <= ovf_c;
      end
      for (int k = 1; k < LATENCY; k++) begin
        if (rdy[k]) begin
          v[k]     <= v[k-1];
          sum_q[k] <= sum_q[k-1];
          co_q[k]  <= co_q[k-1];
          ovf_q[k] <= ovf_q[k-1];
        end
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < LATENCY; k++) begin
      occupancy = occupancy + 5'(v[k]);
    end
  end

  assign out_valid = v[LATENCY-1];
  assign sum       = sum_q[LATENCY-1];
  assign co        = co_q[LATENCY-1];
  assign ovf       = ovf_q[LATENCY-1];

endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - self-checking bench for adder_pipe (WIDTH=4, LATENCY=3)

module tb_adder_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       ci = 1'b0;
  logic       sub = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] sum;
  logic       co;
  logic       ovf;
  logic [4:0] occupancy;

  adder_pipe #(.WIDTH(4), .LATENCY(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .co(co), .ovf(ovf), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference scoreboard: words in flight as {ovf, co, sum}.
  logic [5:0] q[$];
  int         exp_occ;
  bit         got;
  logic [5:0] exp_w;

  logic       s_in_ready, s_out_valid, s_co, s_ovf;
  logic [3:0] s_sum;
  logic [4:0] s_occ;

  // Arithmetic from first principles: unsigned total for carry, signed total for overflow.
  function automatic logic [5:0] ref_add(input int ia, input int ib, input int ici, input int isub);
    int bbv, t, sa, sb, st;
    bbv = isub ? (15 - ib) : ib;
    t   = ia + bbv + ici;
    sa  = (ia  >= 8) ? ia  - 16 : ia;
    sb  = (bbv >= 8) ? bbv - 16 : bbv;
    st  = sa + sb + ici;
    return {((st > 7) || (st < -8)) ? 1'b1 : 1'b0, (t >= 16) ? 1'b1 : 1'b0, 4'(t % 16)};
  endfunction

  // One clock cycle: drive, sample before the edge, update the model for that edge.
  task automatic tick(input bit iv, input int ia, input int ib, input bit ici, input bit isub,
                      input bit ior, input bit ifl);
    in_valid  = iv;
    a         = 4'(ia);
    b         = 4'(ib);
    ci        = ici;
    sub       = isub;
    out_ready = ior;
    flush     = ifl;
    @(negedge clk);
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_sum       = sum;
    s_co        = co;
    s_ovf       = ovf;
    s_occ       = occupancy;
    exp_occ     = q.size();
    got         = 1'b0;
    exp_w       = '0;
    if (ifl) begin
      q.delete();
    end else begin
      if (out_valid && ior) begin
        got = 1'b1;
        if (q.size() > 0) exp_w = q.pop_front();
        else exp_w = {2'b00, ~sum};
      end
      if (iv && in_ready) q.push_back(ref_add(ia, ib, int'(ici), int'(isub)));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b exp 0", in_ready); end
    checks++; if ({ovf, co, sum} !== 6'd0) begin errors++; $display("FAIL reset_result got %0h exp 0", {ovf, co, sum}); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %0b exp 1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    tick(1, 9, 8, 0, 0, 1, 0);
    checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL add_accept got %0b exp 1", s_in_ready); end
    tick(0, 0, 0, 0, 0, 1, 0);
    checks++; if (s_out_valid !== 1'b0 || s_occ !== 5'd1) begin errors++; $display("FAIL add_edge0 got v=%0b occ=%0d exp v=0 occ=1", s_out_valid, s_occ); end
    tick(0, 0, 0, 0, 0, 1, 0);
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL add_edge1 got v=%0b exp 0", s_out_valid); end
    tick(0, 0, 0, 0, 0, 1, 0);
    checks++; if (s_out_valid !== 1'b1 || {s_ovf, s_co, s_sum} !== {1'b1, 1'b1, 4'd1}) begin
      errors++; $display("FAIL add_result got v=%0b sum=%0d co=%0b ovf=%0b exp v=1 sum=1 co=1 ovf=1", s_out_valid, s_sum, s_co, s_ovf);
    end
    tick(0, 0, 0, 0, 0, 1, 0);
    checks++; if (s_occ !== 5'd0) begin errors++; $display("FAIL add_drain_occ got %0d exp 0", s_occ); end
  endtask

  task automatic test_sub();
    int n = 0;
    tick(1, 3, 5, 1, 1, 1, 0);
    tick(1, 7, 15, 1, 1, 1, 0);
    for (int c = 0; c < 6; c++) begin
      tick(0, 0, 0, 0, 0, 1, 0);
      if (got) begin
        if (n == 0) begin
          checks++; if ({s_ovf, s_co, s_sum} !== {1'b0, 1'b0, 4'd14}) begin errors++; $display("FAIL sub_3_5 got sum=%0d co=%0b ovf=%0b exp 14 0 0", s_sum, s_co, s_ovf); end
        end else begin
          checks++; if ({s_ovf, s_co, s_sum} !== {1'b1, 1'b0, 4'd8}) begin errors++; $display("FAIL sub_7_15 got sum=%0d co=%0b ovf=%0b exp 8 0 1", s_sum, s_co, s_ovf); end
        end
        n++;
      end
    end
    checks++; if (n != 2) begin errors++; $display("FAIL sub_count got %0d exp 2", n); end
  endtask

  task automatic test_backpressure();
    int nxt = 0;
    int n = 0;
    bit ior;
    bit prev_stall = 0;
    logic [3:0] prev_sum = '0;
    for (int c = 0; c < 20; c++) begin
      ior = !(c >= 4 && c <= 7);
      tick(nxt < 8, nxt, 1, 0, 0, ior, 0);
      if (nxt < 8 && s_in_ready) nxt++;
      if (s_occ == 5'd3 && !ior) begin
        checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got %0b exp 0 cycle %0d", s_in_ready, c); end
      end
      if (prev_stall) begin
        checks++; if (s_sum !== prev_sum) begin errors++; $display("FAIL bp_stable got %0d exp %0d cycle %0d", s_sum, prev_sum, c); end
      end
      if (got) begin
        n++;
        checks++; if (s_sum !== 4'(n)) begin errors++; $display("FAIL bp_order got %0d exp %0d", s_sum, n); end
      end
      prev_stall = s_out_valid && !ior;
      prev_sum   = s_sum;
    end
    checks++; if (n != 8 || nxt != 8) begin errors++; $display("FAIL bp_count got out=%0d in=%0d exp 8 8", n, nxt); end
  endtask

  task automatic test_bubble();
    tick(1, 2, 3, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(1, 4, 4, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) tick(0, 0, 0, 0, 0, 0, 0);
    checks++; if (s_occ !== 5'd2 || s_out_valid !== 1'b1 || s_sum !== 4'd5) begin
      errors++; $display("FAIL bubble_stall got occ=%0d v=%0b sum=%0d exp 2 1 5", s_occ, s_out_valid, s_sum);
    end
    tick(0, 0, 0, 0, 0, 1, 0);
    checks++; if (!got || s_sum !== 4'd5) begin errors++; $display("FAIL bubble_first got g=%0b sum=%0d exp 1 5", got, s_sum); end
    tick(0, 0, 0, 0, 0, 1, 0);
    checks++; if (!got || s_sum !== 4'd8) begin errors++; $display("FAIL bubble_second got g=%0b sum=%0d exp 1 8", got, s_sum); end
    tick(0, 0, 0, 0, 0, 1, 0);
    checks++; if (s_occ !== 5'd0) begin errors++; $display("FAIL bubble_drain got %0d exp 0", s_occ); end
  endtask

  task automatic test_flush();
    for (int c = 0; c < 3; c++) tick(1, c, 2, 0, 0, 0, 0);
    tick(1, 1, 1, 0, 0, 0, 1);
    checks++; if (s_in_ready !== 1'b0 || s_occ !== 5'd3) begin errors++; $display("FAIL flush_pre got rdy=%0b occ=%0d exp 0 3", s_in_ready, s_occ); end
    tick(0, 0, 0, 0, 0, 0, 0);
    checks++; if (s_out_valid !== 1'b0 || s_occ !== 5'd0) begin errors++; $display("FAIL flush_after got v=%0b occ=%0d exp 0 0", s_out_valid, s_occ); end
    tick(0, 0, 0, 0, 0, 1, 0);
    checks++; if (s_occ !== 5'd0) begin errors++; $display("FAIL flush_no_accept got %0d exp 0", s_occ); end
    // Flush with a non-full pipe: in_ready must still drop.
    tick(1, 1, 1, 0, 0, 1, 1);
    checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %0b exp 0", s_in_ready); end
    tick(0, 0, 0, 0, 0, 1, 0);
    checks++; if (s_occ !== 5'd0) begin errors++; $display("FAIL flush_empty_occ got %0d exp 0", s_occ); end
  endtask

  task automatic test_random();
    bit iv, ior;
    for (int c = 0; c < 300; c++) begin
      iv  = ($urandom_range(0, 3) != 0);
      ior = ($urandom_range(0, 2) != 0);
      tick(iv, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ior, 0);
      checks++; if (s_occ !== 5'(exp_occ)) begin errors++; $display("FAIL rnd_occ got %0d exp %0d cycle %0d", s_occ, exp_occ, c); end
      checks++; if (s_in_ready !== ((exp_occ < 3) || ior)) begin errors++; $display("FAIL rnd_in_ready got %0b occ=%0d or=%0b", s_in_ready, exp_occ, ior); end
      if (got) begin
        checks++; if ({s_ovf, s_co, s_sum} !== exp_w) begin errors++; $display("FAIL rnd_word got %0h exp %0h cycle %0d", {s_ovf, s_co, s_sum}, exp_w, c); end
      end
    end
    for (int c = 0; c < 8; c++) begin
      tick(0, 0, 0, 0, 0, 1, 0);
      if (got) begin
        checks++; if ({s_ovf, s_co, s_sum} !== exp_w) begin errors++; $display("FAIL rnd_drain_word got %0h exp %0h", {s_ovf, s_co, s_sum}, exp_w); end
      end
    end
    checks++; if (q.size() != 0 || s_occ !== 5'd0) begin errors++; $display("FAIL rnd_drain got q=%0d occ=%0d exp 0 0", q.size(), s_occ); end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 3; c++) tick(1, 5, 6, 1, 0, 0, 0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || sum !== 4'd0 || co !== 1'b0 || occupancy !== 5'd0) begin
      errors++; $display("FAIL areset_clear got v=%0b sum=%0d co=%0b occ=%0d exp all 0", out_valid, sum, co, occupancy);
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL areset_in_ready got %0b exp 0", in_ready); end
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1, 15, 1, 0, 0, 1, 0);
    checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL areset_accept got %0b exp 1", s_in_ready); end
    tick(0, 0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 1, 0);
    checks++; if (s_out_valid !== 1'b1 || s_sum !== 4'd0 || s_co !== 1'b1) begin
      errors++; $display("FAIL areset_fresh got v=%0b sum=%0d co=%0b exp 1 0 1", s_out_valid, s_sum, s_co);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_bubble();
    test_flush();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
